// File: rtl/rf_port_arbiter.sv
// Two-requester arbiter for the shared 4x16 register file: round-robin with a
// bounded lock, sequencing each transaction as IDLE -> ISSUE -> RESP.
module rf_port_arbiter #(
  parameter int MAX_LOCK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic        weh0,
  input  logic        weh1,
  input  logic        wel0,
  input  logic        wel1,
  input  logic [1:0]  waddr0,
  input  logic [1:0]  waddr1,
  input  logic [1:0]  raddr0,
  input  logic [1:0]  raddr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic [15:0] rf_in,
  output logic [1:0]  rf_laddr,
  output logic [1:0]  rf_raddr,
  output logic        rf_hwrite,
  output logic        rf_lwrite,
  input  logic [15:0] rf_lout,
  input  logic [15:0] rf_rout,
  output logic        busy
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state, state_nxt;
  logic          grant;      // last winner; 1 after reset so requester 0 leads
  logic          last_lock;
  logic [CW-1:0] lock_cnt;

  logic          arb_go;
  logic          win;
  logic          win_lock;
  logic [CW-1:0] cnt_nxt;

  // The left read port is not needed: writes go through rf_in, reads use the right port.
  logic unused_lout;
  assign unused_lout = ^rf_lout;

  assign busy = (state != IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    arb_go    = 1'b0;
    win       = 1'b0;
    win_lock  = 1'b0;
    cnt_nxt   = '0;

    if (state != ISSUE && (req0 || req1)) begin
      arb_go = 1'b1;
      if (req0 && req1)
        win = (last_lock && lock_cnt < LOCK_MAX) ? grant : ~grant;
      else
        win = req1;
      win_lock = win ? lock1 : lock0;
      if (win_lock)
        cnt_nxt = (win != grant) ? CW'(1) :
                  (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + CW'(1);
    end

    case (state)
      IDLE:    state_nxt = arb_go ? ISSUE : IDLE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = arb_go ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= 1'b1;
      last_lock <= 1'b0;
      lock_cnt  <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      rf_in     <= '0;
      rf_laddr  <= '0;
      rf_raddr  <= '0;
      rf_hwrite <= 1'b0;
      rf_lwrite <= 1'b0;
    end else begin
      state <= state_nxt;
      ack0  <= 1'b0;
      ack1  <= 1'b0;

      if (state == ISSUE) begin
        // The register file wrote at the mid-cycle negedge, so this is post-write data.
        rdata     <= rf_rout;
        rf_hwrite <= 1'b0;
        rf_lwrite <= 1'b0;
        ack0      <= ~grant;
        ack1      <= grant;
      end

      // The rf_* registers double as the transaction register.
      if (arb_go) begin
        grant     <= win;
        last_lock <= win_lock;
        lock_cnt  <= cnt_nxt;
        rf_in     <= win ? wdata1 : wdata0;
        rf_laddr  <= win ? waddr1 : waddr0;
        rf_raddr  <= win ? raddr1 : raddr0;
        rf_hwrite <= win ? weh1 : weh0;
        rf_lwrite <= win ? wel1 : wel0;
      end
    end
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Self-checking bench for rf_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model with its own register-file image.
module tb_rf_port_arbiter;

  localparam int MAX_LOCK = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req [2];
  logic        lock [2];
  logic        weh [2];
  logic        wel [2];
  logic [1:0]  waddr [2];
  logic [1:0]  raddr [2];
  logic [15:0] wdata [2];

  logic        ack0, ack1, rf_hwrite, rf_lwrite, busy;
  logic [15:0] rdata, rf_in, rf_lout, rf_rout;
  logic [1:0]  rf_laddr, rf_raddr;

  logic [15:0] rf_mem [4];   // the register file the arbiter drives
  logic [15:0] ref_mem [4];  // expected contents, updated per transaction

  int checks = 0;
  int errors = 0;

  rf_port_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .req1(req[1]), .lock0(lock[0]), .lock1(lock[1]),
    .weh0(weh[0]), .weh1(weh[1]), .wel0(wel[0]), .wel1(wel[1]),
    .waddr0(waddr[0]), .waddr1(waddr[1]), .raddr0(raddr[0]), .raddr1(raddr[1]),
    .wdata0(wdata[0]), .wdata1(wdata[1]),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .rf_in(rf_in),
    .rf_laddr(rf_laddr), .rf_raddr(rf_raddr),
    .rf_hwrite(rf_hwrite), .rf_lwrite(rf_lwrite),
    .rf_lout(rf_lout), .rf_rout(rf_rout), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rf_hwrite) rf_mem[rf_laddr][15:8] <= rf_in[15:8];
    if (rf_lwrite) rf_mem[rf_laddr][7:0]  <= rf_in[7:0];
  end
  assign rf_lout = rf_mem[rf_laddr];
  assign rf_rout = rf_mem[rf_raddr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    for (int r = 0; r < 2; r++) begin
      req[r] = 0; lock[r] = 0; weh[r] = 0; wel[r] = 0;
      waddr[r] = '0; raddr[r] = '0; wdata[r] = '0;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Issues one transaction and waits (bounded) for its ack; lat = -1 on timeout.
  task automatic txn(input int who, input logic lk, input logic h, input logic l,
                     input logic [1:0] wa, input logic [1:0] ra, input logic [15:0] wd,
                     output logic [15:0] rd, output int lat, output logic saw_we);
    logic [15:0] v;
    lock[who] = lk; weh[who] = h; wel[who] = l;
    waddr[who] = wa; raddr[who] = ra; wdata[who] = wd; req[who] = 1'b1;
    rd = '0; lat = -1; saw_we = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (rf_hwrite || rf_lwrite) saw_we = 1'b1;
      if ((who == 0 ? ack0 : ack1) === 1'b1) begin
        rd = rdata; lat = i;
        break;
      end
    end
    req[who] = 1'b0; lock[who] = 1'b0;
    if (lat > 0) begin
      v = ref_mem[wa];
      if (h) v[15:8] = wd[15:8];
      if (l) v[7:0]  = wd[7:0];
      ref_mem[wa] = v;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({ack0, ack1, busy, rf_hwrite, rf_lwrite, rdata, rf_in, rf_laddr, rf_raddr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b%b busy=%b we=%b%b rdata=%h rf_in=%h la=%h ra=%h exp all zero",
               ack1, ack0, busy, rf_hwrite, rf_lwrite, rdata, rf_in, rf_laddr, rf_raddr);
    end
    req[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ack0, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_held got ack0=%b busy=%b exp 0 0", ack0, busy);
    end
    req[0] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    req[0] = 1; weh[0] = 1; wel[0] = 1; waddr[0] = 2; raddr[0] = 2; wdata[0] = 16'hA55A;
    @(posedge clk); #1;
    checks++;
    if ({busy, ack0, rf_hwrite, rf_lwrite, rf_laddr, rf_raddr, rf_in} !== {4'b1011, 2'd2, 2'd2, 16'hA55A}) begin
      errors++;
      $display("FAIL single_issue got busy=%b ack0=%b we=%b%b la=%0d ra=%0d in=%h exp 1 0 11 2 2 a55a",
               busy, ack0, rf_hwrite, rf_lwrite, rf_laddr, rf_raddr, rf_in);
    end
    wdata[0] = 16'h0000; waddr[0] = 0;   // ignored once latched
    @(posedge clk); #1;
    checks++;
    if ({ack0, ack1, busy, rf_hwrite, rf_lwrite} !== 5'b10100 || rdata !== 16'hA55A) begin
      errors++;
      $display("FAIL single_resp got ack=%b%b busy=%b we=%b%b rdata=%h exp ack0 rdata=a55a",
               ack1, ack0, busy, rf_hwrite, rf_lwrite, rdata);
    end
    req[0] = 0; weh[0] = 0; wel[0] = 0;
    ref_mem[2] = 16'hA55A;
    @(posedge clk); #1;
    checks++;
    if ({ack0, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_done got ack0=%b busy=%b exp 0 0", ack0, busy);
    end
  endtask

  task automatic test_byte_lane();
    logic [15:0] rd; int lat; logic sw;
    txn(1, 0, 1, 1, 2'd1, 2'd1, 16'h1234, rd, lat, sw);
    checks++;
    if (rd !== 16'h1234 || lat !== 2) begin
      errors++; $display("FAIL byte_full got rdata=%h lat=%0d exp 1234 2", rd, lat);
    end
    txn(1, 0, 0, 1, 2'd1, 2'd1, 16'hFFCD, rd, lat, sw);
    checks++;
    if (rd !== 16'h12CD || lat !== 2) begin
      errors++; $display("FAIL byte_low got rdata=%h lat=%0d exp 12cd 2", rd, lat);
    end
    txn(1, 0, 1, 0, 2'd1, 2'd1, 16'hAB00, rd, lat, sw);
    checks++;
    if (rd !== 16'hABCD || lat !== 2) begin
      errors++; $display("FAIL byte_high got rdata=%h lat=%0d exp abcd 2", rd, lat);
    end
  endtask

  task automatic test_pure_read();
    logic [15:0] rd; int lat; logic sw;
    txn(0, 0, 1, 1, 2'd3, 2'd3, 16'h5AC3, rd, lat, sw);
    checks++;
    if (rd !== 16'h5AC3 || sw !== 1'b1) begin
      errors++; $display("FAIL read_setup got rdata=%h we_seen=%b exp 5ac3 1", rd, sw);
    end
    txn(0, 0, 0, 0, 2'd3, 2'd3, 16'hFFFF, rd, lat, sw);
    checks++;
    if (rd !== 16'h5AC3 || sw !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL pure_read got rdata=%h we_seen=%b lat=%0d exp 5ac3 0 2", rd, sw, lat);
    end
    checks++;
    if (rf_mem[3] !== 16'h5AC3) begin
      errors++; $display("FAIL pure_read_mem got R3=%h exp 5ac3", rf_mem[3]);
    end
  endtask

  // Both requesters held with pure reads; records ack owners and cycle numbers.
  task automatic run_held(input int n, output int owner[$], output int when[$]);
    owner.delete(); when.delete();
    req[0] = 1; req[1] = 1;
    for (int cyc = 1; cyc <= 4 * n + 8 && owner.size() < n; cyc++) begin
      @(posedge clk); #1;
      checks++;
      if ((ack0 & ack1) !== 1'b0) begin
        errors++; $display("FAIL dual_ack got ack0=%b ack1=%b exp at most one", ack0, ack1);
      end
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        owner.push_back(ack1 ? 1 : 0);
        when.push_back(cyc);
        checks++;
        if (rdata !== ref_mem[ack1 ? 1 : 2]) begin
          errors++; $display("FAIL held_rdata got %h exp %h", rdata, ref_mem[ack1 ? 1 : 2]);
        end
      end
    end
    req[0] = 0; req[1] = 0; lock[0] = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int owner[$]; int when[$];
    pulse_reset();
    idle_inputs();
    raddr[0] = 2; raddr[1] = 1;
    run_held(6, owner, when);
    checks++;
    if (owner.size() !== 6) begin
      errors++; $display("FAIL contention_count got %0d exp 6", owner.size());
    end
    for (int i = 0; i < owner.size(); i++) begin
      checks++;
      if (owner[i] !== i % 2 || when[i] !== 2 + 2 * i) begin
        errors++;
        $display("FAIL contention_ack%0d got owner=%0d cycle=%0d exp owner=%0d cycle=%0d",
                 i, owner[i], when[i], i % 2, 2 + 2 * i);
      end
    end
  endtask

  task automatic test_lock_bound();
    int owner[$]; int when[$];
    int exp_owner [10];
    exp_owner = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    pulse_reset();
    idle_inputs();
    raddr[0] = 2; raddr[1] = 1; lock[0] = 1;
    run_held(10, owner, when);
    checks++;
    if (owner.size() !== 10) begin
      errors++; $display("FAIL lock_count got %0d exp 10", owner.size());
    end
    for (int i = 0; i < owner.size(); i++) begin
      checks++;
      if (owner[i] !== exp_owner[i] || when[i] !== 2 + 2 * i) begin
        errors++;
        $display("FAIL lock_ack%0d got owner=%0d cycle=%0d exp owner=%0d cycle=%0d",
                 i, owner[i], when[i], exp_owner[i], 2 + 2 * i);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Write data equals current contents, so an interrupted write is harmless either way.
    idle_inputs();
    req[0] = 1; weh[0] = 1; wel[0] = 1; waddr[0] = 2; raddr[0] = 2; wdata[0] = ref_mem[2];
    @(posedge clk); #1;
    checks++;
    if ({busy, rf_hwrite} !== 2'b11) begin
      errors++; $display("FAIL midrst_issue got busy=%b hwrite=%b exp 1 1", busy, rf_hwrite);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ack0, ack1, busy, rf_hwrite, rf_lwrite, rdata, rf_in, rf_laddr, rf_raddr} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got ack=%b%b busy=%b we=%b%b rdata=%h in=%h la=%h ra=%h exp all zero",
               ack1, ack0, busy, rf_hwrite, rf_lwrite, rdata, rf_in, rf_laddr, rf_raddr);
    end
    @(posedge clk); #1;
    checks++;
    if ({ack0, busy} !== 2'b00) begin
      errors++; $display("FAIL midrst_held got ack0=%b busy=%b exp 0 0", ack0, busy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, ack0, rf_hwrite} !== 3'b101) begin
      errors++; $display("FAIL midrst_reissue got busy=%b ack0=%b hwrite=%b exp 1 0 1", busy, ack0, rf_hwrite);
    end
    @(posedge clk); #1;
    checks++;
    if (ack0 !== 1'b1 || rdata !== ref_mem[2]) begin
      errors++; $display("FAIL midrst_ack got ack0=%b rdata=%h exp 1 %h", ack0, rdata, ref_mem[2]);
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic rand_fields(input int r);
    lock[r]  = ($urandom_range(0, 1) == 1);
    weh[r]   = ($urandom_range(0, 3) != 0);
    wel[r]   = ($urandom_range(0, 3) != 0);
    waddr[r] = 2'($urandom_range(0, 3));
    raddr[r] = 2'($urandom_range(0, 3));
    wdata[r] = 16'($urandom);
  endtask

  task automatic test_random();
    logic [15:0] rd; int lat; logic sw;
    int phase = 0;          // 0 idle, 1 issue, 2 resp
    int last_w = 1;
    int streak = 0;         // consecutive locked grants held by last_w
    int w = 0;
    logic m_h = 0, m_l = 0;
    logic [1:0] m_wa = 0, m_ra = 0;
    logic [15:0] m_wd = 0, m_rd = 0;

    txn(0, 0, 1, 1, 2'd0, 2'd0, 16'($urandom), rd, lat, sw);
    pulse_reset();
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      if (phase != 1 && (req[0] || req[1])) begin
        if (req[0] && req[1])
          w = (streak > 0 && streak < MAX_LOCK) ? last_w : 1 - last_w;
        else
          w = req[1] ? 1 : 0;
        if (lock[w]) streak = (w == last_w) ? streak + 1 : 1;
        else         streak = 0;
        last_w = w;
        m_h = weh[w]; m_l = wel[w]; m_wa = waddr[w]; m_ra = raddr[w]; m_wd = wdata[w];
        if (m_h) ref_mem[m_wa][15:8] = m_wd[15:8];
        if (m_l) ref_mem[m_wa][7:0]  = m_wd[7:0];
        m_rd = ref_mem[m_ra];
        phase = 1;
      end else if (phase == 1) begin
        phase = 2;
      end else begin
        phase = 0;
      end

      @(posedge clk); #1;

      checks++;
      if ({busy, ack0, ack1} !== {phase != 0, phase == 2 && w == 0, phase == 2 && w == 1}) begin
        errors++;
        $display("FAIL rand_ctrl c=%0d got busy=%b ack0=%b ack1=%b exp %b %b %b", c, busy, ack0, ack1,
                 phase != 0, phase == 2 && w == 0, phase == 2 && w == 1);
      end
      if (phase == 1) begin
        checks++;
        if ({rf_hwrite, rf_lwrite, rf_laddr, rf_raddr, rf_in} !== {m_h, m_l, m_wa, m_ra, m_wd}) begin
          errors++;
          $display("FAIL rand_issue c=%0d got we=%b%b la=%0d ra=%0d in=%h exp we=%b%b la=%0d ra=%0d in=%h",
                   c, rf_hwrite, rf_lwrite, rf_laddr, rf_raddr, rf_in, m_h, m_l, m_wa, m_ra, m_wd);
        end
      end else begin
        checks++;
        if ({rf_hwrite, rf_lwrite} !== 2'b00) begin
          errors++; $display("FAIL rand_we_idle c=%0d got we=%b%b exp 00", c, rf_hwrite, rf_lwrite);
        end
      end
      if (phase == 2) begin
        checks++;
        if (rdata !== m_rd) begin
          errors++; $display("FAIL rand_rdata c=%0d got %h exp %h", c, rdata, m_rd);
        end
      end

      for (int r = 0; r < 2; r++) begin
        if (phase == 2 && w == r) req[r] = 0;
        if (phase == 1 && w == r) begin
          rand_fields(r);
        end else if (!req[r]) begin
          if ($urandom_range(0, 1) == 1) begin
            rand_fields(r);
            req[r] = 1;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req[r] = 0;
        end
      end
    end
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_byte_lane();
    test_pure_read();
    test_contention();
    test_lock_bound();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the 4x16 register file between two requesters: requester 0 (datapath control) and requester 1 (debug/loader port).
- Each requester posts a transaction with a req/ack handshake: byte-lane write to one register plus read of another.
- Sequences the register-file control lines (address, write enables, write data) so they are stable across the negedge write.
- Returns read data after the write has settled. Round-robin arbitration, with optional bounded lock for bursts.

Parameters:
- MAX_LOCK, 4, maximum consecutive locked grants to one requester before the lock is ignored for one arbitration.

Ports:
- clk  in  1  system clock; arbiter logic on posedge, register file writes on negedge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1 each  transaction request; held until ack.
- lock0, lock1  in  1 each  request to retain the grant for this requester's next request.
- weh0, weh1  in  1 each  write high byte [15:8].
- wel0, wel1  in  1 each  write low byte [7:0].
- waddr0, waddr1  in  2 each  write/left address.
- raddr0, raddr1  in  2 each  read/right address.
- wdata0, wdata1  in  16 each  write data.
- ack0, ack1  out  1 each  one-cycle completion pulse.
- rdata  out  16  read result, valid while either ack is high.
- rf_in  out  16  to register file data input.
- rf_laddr, rf_raddr  out  2 each  to register file left and right address inputs.
- rf_hwrite, rf_lwrite  out  1 each  to register file high/low write enables.
- rf_lout, rf_rout  in  16 each  register file read ports.
- busy  out  1  high in ISSUE and RESP.

Behaviour:
- States: IDLE, ISSUE, RESP.
- IDLE: at posedge, if any req is high, pick a winner, latch its fields into a transaction register, move to ISSUE; otherwise stay.
- ISSUE (exactly one cycle):
  - rf_laddr, rf_raddr, rf_in, rf_hwrite and rf_lwrite are driven from the transaction register. All are register outputs, so they are stable before the negedge.
  - The register file writes at the mid-cycle negedge.
  - At the closing posedge, rdata <= rf_rout. This is the post-write value when raddr equals waddr. Move to RESP.
- RESP (one cycle):
  - ack of the winner is high and rdata is valid. rf_hwrite and rf_lwrite are low.
  - At the closing posedge arbitration is re-run exactly as in IDLE → ISSUE if a req is high, else IDLE.
  - A req still high at this edge is a new transaction, so back-to-back requests are allowed.
- Latency and throughput: req sampled high at edge k → ISSUE in cycle k+1 → ack in cycle k+2. At most one transaction per 2 cycles.
- Arbitration:
  - A single requester always wins.
  - On contention, round-robin: the requester not granted last wins. After reset, requester 0 has priority.
  - Lock: if the last winner had lock high when latched, and its req is high again, it wins regardless of round-robin.
  - A lock counter counts consecutive locked wins. When it reaches MAX_LOCK and the other requester is waiting, lock is ignored and the other requester wins. The counter clears on any non-locked grant or when the winner changes.
- we = 00 is a pure read: no enable pulses, rdata returned normally.
- Enables: rf_hwrite = weh and rf_lwrite = wel, asserted only during ISSUE.
- Fields (we, addresses, data) are sampled only at the latching edge. Changes while waiting or in ISSUE are ignored.
- Dropping req before ack: a transaction already latched still completes and acks; a request not yet latched is simply not served.
- Reset (asynchronous, any time including mid-ISSUE):
  - State → IDLE. ack0/ack1, busy, rf_hwrite, rf_lwrite and rdata → 0.
  - rf_in, rf_laddr and rf_raddr → 0. Lock counter → 0; round-robin pointer → requester 0.
  - Register file contents are not reset. A write interrupted mid-ISSUE may or may not have occurred.
- Release: first arbitration happens at the first posedge after rst_n rises.

Test Plan:
- Single write: req0, weh0 = wel0 = 1, waddr0 = 2, raddr0 = 2, wdata0 = 16'hA55A → ISSUE next cycle with rf_hwrite = rf_lwrite = 1; ack0 two cycles after sampling; rdata = 16'hA55A.
- Byte lane: R1 = 16'h1234, then wel1 only with wdata1 = 16'hFFCD, raddr1 = 1 → ack1 with rdata = 16'h12CD; weh only with 16'hAB00 → 16'hABCD.
- Contention: req0 and req1 held high with no lock → acks alternate 0, 1, 0, 1, each 2 cycles apart; first ack goes to 0 after reset.
- Lock bound: MAX_LOCK = 4, req0 + lock0 held, req1 held → four consecutive ack0, then ack1, then requester 0 regains.
- Pure read: we = 00, raddr = 3 → no enable pulses; rdata equals the prior contents of R3; R3 unchanged afterwards.
- Reset mid-operation: drop rst_n during ISSUE → same cycle all outputs 0, no ack; after release, a pending req is served with normal latency.
